// File: rtl/axi_llc_pkg.sv
// Shared types and default RegBus register map for the LLC flush controller.
package axi_llc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_FLUSH,
        WR_COMMIT,
        RD_FLUSHED,
        WAIT,
        RESP
    } flush_state_e;

    localparam logic [31:0] CFG_FLUSH_ADDR = 32'h0000_0008;
    localparam logic [31:0] COMMIT_ADDR    = 32'h0000_0018;
    localparam logic [31:0] FLUSHED_ADDR   = 32'h0000_0028;

endpackage

// File: rtl/axi_llc_flush_ctrl_if.sv
// Command/response handshake plus RegBus initiator signals of the flush controller.
interface axi_llc_flush_ctrl_if #(
    parameter int unsigned SetAssociativity = 8
);
    logic                        cmd_valid_i;
    logic                        cmd_ready_o;
    logic [SetAssociativity-1:0] cmd_way_mask_i;
    logic                        done_valid_o;
    logic                        done_ready_i;
    logic                        done_error_o;
    logic                        done_timeout_o;
    logic                        busy_o;

    logic [31:0]                 conf_req_addr;
    logic                        conf_req_w;
    logic [31:0]                 conf_req_wdata;
    logic [3:0]                  conf_req_wstrb;
    logic                        conf_req_valid;
    logic [31:0]                 conf_resp_rdata;
    logic                        conf_resp_error;
    logic                        conf_resp_ready;

    // Controller view: drives the RegBus request and the done response.
    modport master (
        input  cmd_valid_i, cmd_way_mask_i, done_ready_i,
        input  conf_resp_rdata, conf_resp_error, conf_resp_ready,
        output cmd_ready_o, done_valid_o, done_error_o, done_timeout_o, busy_o,
        output conf_req_addr, conf_req_w, conf_req_wdata, conf_req_wstrb, conf_req_valid
    );

    modport slave (
        output cmd_valid_i, cmd_way_mask_i, done_ready_i,
        output conf_resp_rdata, conf_resp_error, conf_resp_ready,
        input  cmd_ready_o, done_valid_o, done_error_o, done_timeout_o, busy_o,
        input  conf_req_addr, conf_req_w, conf_req_wdata, conf_req_wstrb, conf_req_valid
    );

endinterface

// File: rtl/axi_llc_flush_ctrl_counter.sv
// Loadable up/down counter, port-compatible subset of the common_cells counter.
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = d_i;
        end else if (en_i) begin
            cnt_d = down_i ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/axi_llc_flush_ctrl.sv
// RegBus initiator that writes the LLC flush mask, commits it and polls the
// flushed-status register until the selected ways are clean, a bus error or a timeout.
module axi_llc_flush_ctrl
    import axi_llc_pkg::*;
#(
    parameter int unsigned SetAssociativity = 8,
    parameter logic [31:0] CfgFlushAddr     = CFG_FLUSH_ADDR,
    parameter logic [31:0] CommitAddr       = COMMIT_ADDR,
    parameter logic [31:0] FlushedAddr      = FLUSHED_ADDR,
    parameter int unsigned PollInterval     = 16,
    parameter int unsigned MaxPolls         = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi_llc_flush_ctrl_if.master bus
);

    localparam int unsigned PollW = $clog2(MaxPolls + 1);
    localparam int unsigned IntW  = (PollInterval > 1) ? $clog2(PollInterval) : 1;

    flush_state_e                state_q, state_d;
    logic [SetAssociativity-1:0] mask_q, mask_d;
    logic [PollW-1:0]            poll_q, poll_d;
    logic                        err_q, err_d;
    logic                        to_q, to_d;
    logic                        int_load, int_en;
    logic [IntW-1:0]             int_q;
    logic                        match;

    assign match = ((bus.conf_resp_rdata[SetAssociativity-1:0] & mask_q) == mask_q);

    counter #(
        .WIDTH (IntW)
    ) i_interval_cnt (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .clear_i (rst_i),
        .en_i    (int_en),
        .load_i  (int_load),
        .down_i  (1'b1),
        .d_i     (IntW'(PollInterval - 1)),
        .q_o     (int_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            poll_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // In the three request states valid is high by construction, so ready alone is the handshake.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        poll_d   = poll_q;
        err_d    = err_q;
        to_d     = to_q;
        int_load = 1'b0;
        int_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    mask_d  = bus.cmd_way_mask_i;
                    poll_d  = '0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = WR_FLUSH;
                end
            end
            WR_FLUSH: begin
                if (bus.conf_resp_ready) begin
                    if (bus.conf_resp_error) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WR_COMMIT;
                    end
                end
            end
            WR_COMMIT: begin
                if (bus.conf_resp_ready) begin
                    if (bus.conf_resp_error) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = RD_FLUSHED;
                    end
                end
            end
            RD_FLUSHED: begin
                if (bus.conf_resp_ready) begin
                    poll_d = poll_q + PollW'(1);
                    if (bus.conf_resp_error) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (match) begin
                        state_d = RESP;
                    end else if (poll_d == PollW'(MaxPolls)) begin
                        err_d   = 1'b1;
                        to_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        int_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (int_q == '0) begin
                    state_d = RD_FLUSHED;
                end else begin
                    int_en = 1'b1;
                end
            end
            RESP: begin
                if (bus.done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready_o    = (state_q == IDLE);
        bus.busy_o         = (state_q != IDLE);
        bus.done_valid_o   = (state_q == RESP);
        bus.done_error_o   = (state_q == RESP) && err_q;
        bus.done_timeout_o = (state_q == RESP) && to_q;
        bus.conf_req_valid = 1'b0;
        bus.conf_req_w     = 1'b0;
        bus.conf_req_addr  = '0;
        bus.conf_req_wdata = '0;
        bus.conf_req_wstrb = '0;
        unique case (state_q)
            WR_FLUSH: begin
                bus.conf_req_valid = 1'b1;
                bus.conf_req_w     = 1'b1;
                bus.conf_req_addr  = CfgFlushAddr;
                bus.conf_req_wdata = 32'(mask_q);
                bus.conf_req_wstrb = '1;
            end
            WR_COMMIT: begin
                bus.conf_req_valid = 1'b1;
                bus.conf_req_w     = 1'b1;
                bus.conf_req_addr  = CommitAddr;
                bus.conf_req_wdata = 32'h1;
                bus.conf_req_wstrb = '1;
            end
            RD_FLUSHED: begin
                bus.conf_req_valid = 1'b1;
                bus.conf_req_addr  = FlushedAddr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_llc_flush_ctrl.sv
// Directed and randomized checks of the flush controller against a transaction-level model.
module tb_axi_llc_flush_ctrl;

    localparam int unsigned SA = 8;
    localparam int unsigned PI = 16;
    localparam int unsigned MP = 4;

    typedef struct {
        logic [31:0] addr;
        logic        w;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int unsigned gap;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    acc_t        exp_q[$];
    logic [31:0] flushed[$];
    int          err_at;
    logic        exp_err, exp_to;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_llc_flush_ctrl_if #(.SetAssociativity(SA)) bus ();

    axi_llc_flush_ctrl #(
        .SetAssociativity (SA),
        .PollInterval     (PI),
        .MaxPolls         (MP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push_acc(input logic [31:0] addr, input logic w, input logic [31:0] wdata,
                                     input logic [31:0] rdata, input int unsigned gap);
        acc_t a;
        a.addr  = addr;
        a.w     = w;
        a.wdata = wdata;
        a.wstrb = w ? 4'hF : 4'h0;
        a.rdata = rdata;
        a.err   = (err_at == exp_q.size());
        a.gap   = gap;
        exp_q.push_back(a);
    endfunction

    // Expected access list and outcome: write mask, commit, then poll until clean/timeout/error.
    function automatic void build_model(input logic [SA-1:0] mask);
        logic [31:0] r;
        exp_q.delete();
        exp_err = 1'b0;
        exp_to  = 1'b0;
        push_acc(32'h08, 1'b1, 32'(mask), $urandom, 0);
        if (exp_q[0].err) begin exp_err = 1'b1; return; end
        push_acc(32'h18, 1'b1, 32'h1, $urandom, 0);
        if (exp_q[1].err) begin exp_err = 1'b1; return; end
        for (int k = 0; k < int'(MP); k++) begin
            r = (k < flushed.size()) ? flushed[k] : flushed[flushed.size()-1];
            push_acc(32'h28, 1'b0, 32'h0, r, (k == 0) ? 0 : PI);
            if (exp_q[exp_q.size()-1].err) begin exp_err = 1'b1; return; end
            if ((r[SA-1:0] & mask) == mask) return;
            if (k == int'(MP) - 1) begin exp_err = 1'b1; exp_to = 1'b1; end
        end
    endfunction

    task automatic run_cmd(input logic [SA-1:0] mask, input int unsigned max_delay,
                           input bit check_lat, input int abort_at);
        int unsigned c0, gap, d;
        build_model(mask);
        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready_o, 1);
        check("idle_busy", bus.busy_o, 0);
        bus.cmd_valid_i    = 1'b1;
        bus.cmd_way_mask_i = mask;
        @(negedge clk);
        bus.cmd_valid_i    = 1'b0;
        bus.cmd_way_mask_i = SA'($urandom);
        c0 = cyc;
        check("busy_after_accept", bus.busy_o, 1);
        check("cmd_ready_after_accept", bus.cmd_ready_o, 0);
        foreach (exp_q[i]) begin
            gap = 0;
            while (!bus.conf_req_valid && gap < 200) begin
                check("no_early_done", bus.done_valid_o, 0);
                gap++;
                @(negedge clk);
            end
            check("req_gap", gap, exp_q[i].gap);
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_req_valid", bus.conf_req_valid, 0);
                check("rst_cmd_ready", bus.cmd_ready_o, 1);
                check("rst_busy", bus.busy_o, 0);
                return;
            end
            d = $urandom_range(0, max_delay);
            for (int unsigned j = 0; j <= d; j++) begin
                check("req_valid", bus.conf_req_valid, 1);
                check("req_addr", bus.conf_req_addr, exp_q[i].addr);
                check("req_w", bus.conf_req_w, exp_q[i].w);
                check("req_wdata", bus.conf_req_wdata, exp_q[i].wdata);
                check("req_wstrb", bus.conf_req_wstrb, exp_q[i].wstrb);
                if (j < d) begin
                    bus.conf_resp_ready = 1'b0;
                    bus.conf_resp_rdata = $urandom;
                    bus.conf_resp_error = 1'($urandom_range(0, 1));
                end else begin
                    bus.conf_resp_ready = 1'b1;
                    bus.conf_resp_rdata = exp_q[i].rdata;
                    bus.conf_resp_error = exp_q[i].err;
                end
                @(negedge clk);
            end
            bus.conf_resp_ready = 1'b0;
            bus.conf_resp_rdata = $urandom;
            bus.conf_resp_error = 1'($urandom_range(0, 1));
        end
        gap = 0;
        while (!bus.done_valid_o && gap < 50) begin
            check("no_extra_req", bus.conf_req_valid, 0);
            gap++;
            @(negedge clk);
        end
        check("done_valid", bus.done_valid_o, 1);
        if (check_lat) check("done_latency", cyc - c0, 3);
        check("done_error", bus.done_error_o, exp_err);
        check("done_timeout", bus.done_timeout_o, exp_to);
        check("resp_cmd_ready", bus.cmd_ready_o, 0);
        check("resp_busy", bus.busy_o, 1);
        check("resp_req_valid", bus.conf_req_valid, 0);
        d = $urandom_range(0, 3);
        repeat (d) begin
            @(negedge clk);
            check("done_hold", bus.done_valid_o, 1);
            check("done_error_hold", bus.done_error_o, exp_err);
            check("done_timeout_hold", bus.done_timeout_o, exp_to);
        end
        bus.done_ready_i = 1'b1;
        @(negedge clk);
        bus.done_ready_i = 1'b0;
        check("done_dropped", bus.done_valid_o, 0);
        check("back_idle_ready", bus.cmd_ready_o, 1);
        check("back_idle_busy", bus.busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SA-1:0] m;
        int unsigned   n;
        rst                 = 1'b1;
        bus.cmd_valid_i     = 1'b0;
        bus.cmd_way_mask_i  = '0;
        bus.done_ready_i    = 1'b0;
        bus.conf_resp_rdata = '0;
        bus.conf_resp_error = 1'b0;
        bus.conf_resp_ready = 1'b0;
        err_at              = -1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready_o", bus.cmd_ready_o, 1);
        check("rst_busy_o", bus.busy_o, 0);
        check("rst_done_valid", bus.done_valid_o, 0);
        check("rst_done_error", bus.done_error_o, 0);
        check("rst_done_timeout", bus.done_timeout_o, 0);
        check("rst_conf_valid", bus.conf_req_valid, 0);
        check("rst_conf_w", bus.conf_req_w, 0);
        check("rst_conf_addr", bus.conf_req_addr, 0);
        check("rst_conf_wdata", bus.conf_req_wdata, 0);
        check("rst_conf_wstrb", bus.conf_req_wstrb, 0);
        rst = 1'b0;

        flushed = {32'h0F};
        run_cmd(8'h0F, 0, 1'b1, -1);
        flushed = {32'h3F, 32'h7F, 32'hFF};
        run_cmd(8'hFF, 0, 1'b0, -1);
        flushed = {32'h00};
        run_cmd(8'hA5, 2, 1'b0, -1);
        err_at = 1;
        flushed = {32'hFF};
        run_cmd(8'h3C, 0, 1'b0, -1);
        err_at = 2;
        run_cmd(8'hFF, 1, 1'b0, -1);
        err_at = -1;
        flushed = {32'h00, 32'h00, 32'h00, 32'h81};
        run_cmd(8'h81, 0, 1'b0, -1);
        flushed = {32'h00};
        run_cmd(8'h00, 0, 1'b1, -1);
        run_cmd(8'hF0, 1, 1'b0, 2);
        flushed = {32'hFFFF_FFF0};
        run_cmd(8'hF0, 0, 1'b1, -1);

        repeat (25) begin
            m = SA'($urandom);
            n = $urandom_range(1, 4);
            flushed.delete();
            repeat (n) flushed.push_back(($urandom_range(0, 2) == 0) ? ($urandom | 32'(m)) : $urandom);
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_cmd(m, 5, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
